// File: rtl/wrapper_packet_construct_fifo_if.sv
// -----------------------------------------------------------------------------
// wrapper_packet_construct_fifo_if
// Bundles the register-write channel (from the AHB VR interface) and the
// packet valid/ready channel (towards the accelerator engine) of
// wrapper_packet_construct_fifo.
//   master : drives addr/read_en/write_en/byte_strobe/wdata and
//            packet_data_ready (host side plus engine side)
//   slave  : the packet constructor itself
// Parameters: ADDRWIDTH (register byte address width), PACKETWIDTH (bits).
// -----------------------------------------------------------------------------
interface wrapper_packet_construct_fifo_if #(
    parameter int ADDRWIDTH   = 11,
    parameter int PACKETWIDTH = 512
);
    logic [ADDRWIDTH-1:0]   addr;
    logic                   read_en;
    logic                   write_en;
    logic [3:0]             byte_strobe;
    logic [31:0]            wdata;
    logic [31:0]            rdata;
    logic                   wready;
    logic                   rready;
    logic [PACKETWIDTH-1:0] packet_data;
    logic                   packet_data_last;
    logic                   packet_data_valid;
    logic                   packet_data_ready;

    modport master (
        output addr, read_en, write_en, byte_strobe, wdata, packet_data_ready,
        input  rdata, wready, rready, packet_data, packet_data_last, packet_data_valid
    );

    modport slave (
        input  addr, read_en, write_en, byte_strobe, wdata, packet_data_ready,
        output rdata, wready, rready, packet_data, packet_data_last, packet_data_valid
    );
endinterface

// File: rtl/wrapper_packet_construct_fifo.sv
// -----------------------------------------------------------------------------
// wrapper_packet_construct_fifo
// Assembles 32-bit register writes into PACKETWIDTH-bit packets and queues up
// to DEPTH finished packets for the engine, so the host can build packet N+1
// while the engine is still consuming packet N.
// Ports:
//   hclk, hreset : clock and synchronous active-high reset
//   bus (slave)  : addr/read_en/write_en/byte_strobe/wdata -> rdata/wready/rready
//                  packet_data/packet_data_last/packet_data_valid <- packet_data_ready
// Word index = addr[$clog2(NW)+1:2]; addr[ADDRWIDTH-1] is the LAST alias.
// Optional macro WRAPPER_PKT_CONSTRUCT_STATUS_EN: addr[ADDRWIDTH-2]=1 selects a
// read-only status word {16'h0, count[7:0], 7'h0, partial}.
// -----------------------------------------------------------------------------
module wrapper_packet_construct_fifo #(
    parameter int ADDRWIDTH   = 11,
    parameter int PACKETWIDTH = 512,
    parameter int DEPTH       = 2
) (
    input  logic                           hclk,
    input  logic                           hreset,
    wrapper_packet_construct_fifo_if.slave bus
);
    localparam int NW   = PACKETWIDTH / 32;
    localparam int WIW  = $clog2(NW);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    localparam logic [WIW-1:0]  LAST_W  = WIW'(NW - 1);
    localparam logic [WIW:0]    NW_V    = (WIW + 1)'(NW);
    localparam logic [PTRW-1:0] PTR_MAX = PTRW'(DEPTH - 1);
    localparam logic [CNTW-1:0] DEPTH_V = CNTW'(DEPTH);

    logic [PACKETWIDTH-1:0] asm_q, asm_d, merged_s;
    logic                   partial_q, partial_d;
    logic [PACKETWIDTH-1:0] mem_q [DEPTH];
    logic [PACKETWIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]       last_q, last_d;
    logic [PTRW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]        count_q, count_d;

    logic [WIW-1:0] widx_s;
    logic           word_ok_s, status_sel_s, wready_s, wr_acc_s, asm_wr_s, push_s, pop_s;
    logic [31:0]    status_word_s, rdata_s;
    logic           addr_unused_s;

    assign widx_s    = bus.addr[WIW+1:2];
    // Only reachable when NW is not a power of two: such writes are swallowed.
    assign word_ok_s = ({1'b0, widx_s} < NW_V);

`ifdef WRAPPER_PKT_CONSTRUCT_STATUS_EN
    assign status_sel_s  = bus.addr[ADDRWIDTH-2];
    assign status_word_s = {16'h0000, 8'(count_q), 7'h00, partial_q};
`else
    assign status_sel_s  = 1'b0;
    assign status_word_s = 32'h0000_0000;
`endif

    assign addr_unused_s = ^{bus.addr[1:0], bus.addr[ADDRWIDTH-2:WIW+2]};

    // wready depends on stored count only, never on packet_data_ready.
    assign wready_s = (count_q < DEPTH_V);
    assign wr_acc_s = bus.write_en & wready_s;
    assign asm_wr_s = wr_acc_s & ~status_sel_s & word_ok_s;
    assign push_s   = asm_wr_s & (widx_s == LAST_W);
    assign pop_s    = (count_q != {CNTW{1'b0}}) & bus.packet_data_ready;

    // Byte-merge the incoming write into the addressed assembly word.
    always_comb begin
        merged_s = asm_q;
        if (word_ok_s) begin
            for (int b = 0; b < 4; b++) begin
                merged_s[(int'(widx_s) * 32) + (b * 8) +: 8] =
                    bus.byte_strobe[b] ? bus.wdata[b*8 +: 8]
                                       : asm_q[(int'(widx_s) * 32) + (b * 8) +: 8];
            end
        end else begin
            merged_s = asm_q;
        end
    end

    // Next state for the assembly register, FIFO storage, pointers and count.
    always_comb begin
        asm_d     = asm_q;
        partial_d = partial_q;
        mem_d     = mem_q;
        last_d    = last_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (push_s) begin
            // Final word: the merged packet goes straight into the FIFO and
            // the assembly register restarts from zero on the same edge.
            mem_d[wr_ptr_q]  = merged_s;
            last_d[wr_ptr_q] = bus.addr[ADDRWIDTH-1];
            wr_ptr_d         = (wr_ptr_q == PTR_MAX) ? {PTRW{1'b0}} : wr_ptr_q + 1'b1;
            asm_d            = {PACKETWIDTH{1'b0}};
            partial_d        = 1'b0;
        end else if (asm_wr_s) begin
            asm_d     = merged_s;
            partial_d = 1'b1;
        end else begin
            asm_d     = asm_q;
            partial_d = partial_q;
        end

        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? {PTRW{1'b0}} : rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous reset that discards all buffered data.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            asm_q     <= {PACKETWIDTH{1'b0}};
            partial_q <= 1'b0;
            mem_q     <= '{default: {PACKETWIDTH{1'b0}}};
            last_q    <= {DEPTH{1'b0}};
            wr_ptr_q  <= {PTRW{1'b0}};
            rd_ptr_q  <= {PTRW{1'b0}};
            count_q   <= {CNTW{1'b0}};
        end else begin
            asm_q     <= asm_d;
            partial_q <= partial_d;
            mem_q     <= mem_d;
            last_q    <= last_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Combinational register read: status word, assembly word, or zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (!bus.read_en) begin
            rdata_s = 32'h0000_0000;
        end else if (status_sel_s) begin
            rdata_s = status_word_s;
        end else if (word_ok_s) begin
            rdata_s = asm_q[int'(widx_s) * 32 +: 32];
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.rdata             = rdata_s;
    assign bus.wready            = wready_s;
    assign bus.rready            = 1'b1;
    assign bus.packet_data       = mem_q[rd_ptr_q];
    assign bus.packet_data_last  = last_q[rd_ptr_q];
    assign bus.packet_data_valid = (count_q != {CNTW{1'b0}});
endmodule

// File: tb/tb_wrapper_packet_construct_fifo.sv
// -----------------------------------------------------------------------------
// tb_wrapper_packet_construct_fifo
// Directed bench for wrapper_packet_construct_fifo (PACKETWIDTH=512, DEPTH=2).
// A queue-of-packets model tracks what the FIFO must hold; a negedge compare
// process checks every output against it each cycle, and the directed
// sequences add hand-computed literal expectations.
// Builds with or without WRAPPER_PKT_CONSTRUCT_STATUS_EN.
// -----------------------------------------------------------------------------
module tb_wrapper_packet_construct_fifo;
    localparam int AW    = 11;
    localparam int PW    = 512;
    localparam int DEPTH = 2;

    typedef struct {
        logic          last;
        logic [PW-1:0] data;
    } pkt_t;

    logic hclk;
    logic hreset;
    int   n_cmp;
    int   n_bad;
    logic checking;

    pkt_t        m_q[$];
    logic [31:0] m_asm [16];
    logic        m_partial;

    wrapper_packet_construct_fifo_if #(.ADDRWIDTH(AW), .PACKETWIDTH(PW)) bus ();

    wrapper_packet_construct_fifo #(.ADDRWIDTH(AW), .PACKETWIDTH(PW), .DEPTH(DEPTH)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic status_region(input logic [AW-1:0] a);
`ifdef WRAPPER_PKT_CONSTRUCT_STATUS_EN
        return a[9];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_rdata();
        if (!bus.read_en) return 32'h0;
        if (status_region(bus.addr)) return {16'h0, 8'(m_q.size()), 7'h0, m_partial};
        return m_asm[bus.addr[5:2]];
    endfunction

    // Reference model: queue of finished packets plus a word array for assembly.
    initial begin
        forever begin
            logic acc, pop;
            int   w;
            pkt_t p;
            @(posedge hclk);
            if (hreset) begin
                m_q.delete();
                for (int i = 0; i < 16; i++) m_asm[i] = 32'h0;
                m_partial = 1'b0;
            end else begin
                acc = bus.write_en && (m_q.size() < DEPTH);
                pop = (m_q.size() != 0) && bus.packet_data_ready;
                if (pop) void'(m_q.pop_front());
                if (acc && !status_region(bus.addr)) begin
                    w = int'(bus.addr[5:2]);
                    for (int b = 0; b < 4; b++)
                        if (bus.byte_strobe[b]) m_asm[w][b*8 +: 8] = bus.wdata[b*8 +: 8];
                    m_partial = 1'b1;
                    if (w == 15) begin
                        p.last = bus.addr[10];
                        for (int k = 0; k < 16; k++) p.data[k*32 +: 32] = m_asm[k];
                        m_q.push_back(p);
                        for (int k = 0; k < 16; k++) m_asm[k] = 32'h0;
                        m_partial = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge hclk);
            if (checking) begin
                chk("valid", bus.packet_data_valid, m_q.size() != 0);
                chk("wready", bus.wready, m_q.size() < DEPTH);
                chk("rready", bus.rready, 1'b1);
                chk("rdata", bus.rdata, model_rdata());
                if (m_q.size() != 0) begin
                    chk("data", bus.packet_data, m_q[0].data);
                    chk("last", bus.packet_data_last, m_q[0].last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Holds a write until the model says it is accepted (bounded).
    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        logic acc;
        int   n;
        bus.addr = a; bus.wdata = d; bus.byte_strobe = be; bus.write_en = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge hclk);
            acc = (m_q.size() < DEPTH);
            tick();
            n++;
        end
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_timeout: addr %0h not accepted within 100 cycles", a);
        end
        bus.write_en = 1'b0;
    endtask

    task automatic wr_words(input logic [15:0] tag, input logic lst, input int first, input int lastw);
        for (int w = first; w <= lastw; w++)
            wr({lst, 4'h0, 4'(w), 2'b00}, {tag, 16'(w)}, 4'hF);
    endtask

    task automatic rd(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
        bus.addr = a; bus.read_en = 1'b1;
        @(negedge hclk);
        chk(name, bus.rdata, exp);
        tick();
        bus.read_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; checking = 1'b0;
        hreset = 1'b1;
        bus.addr = '0; bus.read_en = 1'b0; bus.write_en = 1'b0;
        bus.byte_strobe = 4'h0; bus.wdata = 32'h0; bus.packet_data_ready = 1'b0;
        repeat (3) tick();
        hreset = 1'b0;
        checking = 1'b1;

        // Reset state.
        @(negedge hclk);
        chk("rst_valid", bus.packet_data_valid, 1'b0);
        chk("rst_wready", bus.wready, 1'b1);
        chk("rst_data", bus.packet_data, {PW{1'b0}});
        chk("rst_last", bus.packet_data_last, 1'b0);
        chk("rst_rdata", bus.rdata, 32'h0);
        tick();

        // Words 0..15 = 0..F, last write at 11'h43C, engine ready.
        bus.packet_data_ready = 1'b1;
        for (int w = 0; w < 15; w++) wr(11'(w * 4), 32'(w), 4'hF);
        wr(11'h43C, 32'h0000_000F, 4'hF);
        @(negedge hclk);
        chk("t1_valid", bus.packet_data_valid, 1'b1);
        chk("t1_word15", bus.packet_data[511:480], 32'h0000_000F);
        chk("t1_word1", bus.packet_data[63:32], 32'h0000_0001);
        chk("t1_last", bus.packet_data_last, 1'b1);
        tick();
        @(negedge hclk);
        chk("t1_popped", bus.packet_data_valid, 1'b0);
        tick();
        bus.packet_data_ready = 1'b0;

        // Fill the FIFO, stall the next write, release it with a one-cycle pop.
        wr_words(16'h000A, 1'b0, 0, 15);
        wr_words(16'h000B, 1'b1, 0, 15);
        @(negedge hclk);
        chk("t2_full_wready", bus.wready, 1'b0);
        tick();
        bus.addr = 11'h000; bus.wdata = 32'h000C_0000; bus.byte_strobe = 4'hF; bus.write_en = 1'b1;
        repeat (2) begin
            @(negedge hclk);
            chk("t2_stall_wready", bus.wready, 1'b0);
            tick();
        end
        bus.packet_data_ready = 1'b1;
        @(negedge hclk);
        chk("t2_head_a", bus.packet_data[31:0], 32'h000A_0000);
        tick();
        bus.packet_data_ready = 1'b0;
        @(negedge hclk);
        chk("t2_wready_back", bus.wready, 1'b1);
        chk("t2_head_b", bus.packet_data[31:0], 32'h000B_0000);
        chk("t2_head_b_last", bus.packet_data_last, 1'b1);
        tick();
        bus.write_en = 1'b0;
        wr_words(16'h000C, 1'b0, 1, 15);
        bus.packet_data_ready = 1'b1;
        @(negedge hclk);
        chk("t2_order_b", bus.packet_data[63:32], 32'h000B_0001);
        tick();
        @(negedge hclk);
        chk("t2_order_c0", bus.packet_data[31:0], 32'h000C_0000);
        chk("t2_order_c15", bus.packet_data[511:480], 32'h000C_000F);
        chk("t2_c_last", bus.packet_data_last, 1'b0);
        tick();
        bus.packet_data_ready = 1'b0;

        // Byte-strobed merge and read-back.
        wr(11'h008, 32'h1122_3344, 4'hF);
        wr(11'h008, 32'hAABB_CCDD, 4'b0101);
        rd("t3_merge", 11'h008, 32'h11BB_33DD);
        rd("t3_unwritten", 11'h014, 32'h0);
        wr(11'h03C, 32'hFFFF_FFFF, 4'h0);
        @(negedge hclk);
        chk("t3_pkt_word2", bus.packet_data[95:64], 32'h11BB_33DD);
        chk("t3_pkt_low", bus.packet_data[63:0], 64'h0);
        chk("t3_pkt_word15", bus.packet_data[511:480], 32'h0);
        tick();

        // Final write and pop in the same cycle with one packet queued.
        wr_words(16'h000D, 1'b0, 0, 14);
        bus.packet_data_ready = 1'b1;
        wr(11'h03C, 32'h000D_000F, 4'hF);
        bus.packet_data_ready = 1'b0;
        @(negedge hclk);
        chk("t4_valid", bus.packet_data_valid, 1'b1);
        chk("t4_wready", bus.wready, 1'b1);
        chk("t4_head_d", bus.packet_data[31:0], 32'h000D_0000);
        tick();

        // Reset mid-packet with a packet queued.
        wr_words(16'h000E, 1'b0, 0, 6);
        rd("t5_pre_word6", 11'h018, 32'h000E_0006);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        @(negedge hclk);
        chk("t5_valid", bus.packet_data_valid, 1'b0);
        chk("t5_wready", bus.wready, 1'b1);
        tick();
        for (int w = 0; w < 16; w++) rd("t5_word_zero", 11'(w * 4), 32'h0);
        wr_words(16'h000F, 1'b0, 7, 15);
        @(negedge hclk);
        chk("t5_low_zero", bus.packet_data[223:0], 224'h0);
        chk("t5_word7", bus.packet_data[255:224], 32'h000F_0007);
        chk("t5_last", bus.packet_data_last, 1'b0);
        tick();
        bus.packet_data_ready = 1'b1;
        tick();
        bus.packet_data_ready = 1'b0;

`ifdef WRAPPER_PKT_CONSTRUCT_STATUS_EN
        // Status word with one packet queued and three words written.
        wr_words(16'h0006, 1'b0, 0, 15);
        wr_words(16'h0007, 1'b0, 0, 2);
        rd("t6_status", 11'h200, 32'h0000_0101);
        wr(11'h23C, 32'hDEAD_BEEF, 4'hF);
        rd("t6_status_after_wr", 11'h200, 32'h0000_0101);
        rd("t6_word2", 11'h008, 32'h0007_0002);
`endif

        // Drain whatever remains (bounded).
        bus.packet_data_ready = 1'b1;
        for (int i = 0; i < 10 && m_q.size() != 0; i++) tick();
        tick();
        bus.packet_data_ready = 1'b0;
        @(negedge hclk);
        chk("end_empty", bus.packet_data_valid, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
